add_sub_pipe: RTL and testbench

Parametrised, pipelined ripple-carry adder/subtractor, the successor of the team's 4-bit ripple adder.
- Splits a WIDTH-bit operation into STAGES ripple segments, with the carry registered between segments.
- Adds carry-in, carry-out, signed overflow, a zero flag and a valid/ready handshake.
- Used as the datapath arithmetic unit in front of ALU/accumulator blocks.

---
 rtl/add_sub_pipe_pkg.sv | 30 +++
 rtl/add_sub_pipe_rca_seg.sv | 33 +++
 rtl/add_sub_pipe.sv | 153 +++++++++++++++
 tb/tb_add_sub_pipe.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_sub_pipe_pkg.sv
// ============================================================================
// Package : add_pkg
// Shared types and helpers for the add_sub_pipe pipelined adder/subtractor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package add_pkg;

  typedef struct packed {
    logic valid;
    logic sub;
  } stage_ctl_t;

  function automatic int seg_width(input int width, input int stages);
    return width / stages;
  endfunction

  // Saturation patterns; callers truncate to their own width (widths up to 64).
  function automatic logic [63:0] sat_max_pat(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min_pat(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/add_sub_pipe_rca_seg.sv
// ============================================================================
// Module  : rca_seg
// W-bit combinational ripple-carry segment built from full-adder cells.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rca_seg #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb_in
);

  logic [W:0] w_c;

  assign w_c[0] = ci;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign s[i]     = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign co       = w_c[W];
  assign c_msb_in = w_c[W-1];

endmodule

`default_nettype wire

// File: rtl/add_sub_pipe.sv
// ============================================================================
// Module  : add_sub_pipe
// Pipelined ripple-carry adder/subtractor, STAGES segments, valid/ready flow.
// Optional: define ADD_SUB_PIPE_SAT_EN for signed saturation of the result.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module add_sub_pipe
  import add_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SEG  = seg_width(WIDTH, STAGES);
  localparam int LAST = STAGES - 1;
  localparam logic [WIDTH-1:0] c_seg_mask = WIDTH'({SEG{1'b1}});

  if (WIDTH % STAGES != 0) begin : g_bad_cfg
    $error("add_sub_pipe: WIDTH (%0d) must be a multiple of STAGES (%0d)", WIDTH, STAGES);
  end

  logic             w_adv;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;
  logic             w_ovf;
  logic [WIDTH-1:0] w_res;

  // Stage k registers hold the state after segment k has been added.
  stage_ctl_t       r_ctl   [STAGES];
  logic [WIDTH-1:0] r_a     [STAGES];
  logic [WIDTH-1:0] r_b     [STAGES];
  logic [WIDTH-1:0] r_sum   [STAGES];
  logic             r_c     [STAGES];

  stage_ctl_t       w_ctl_in  [STAGES];
  logic [WIDTH-1:0] w_in_a    [STAGES];
  logic [WIDTH-1:0] w_in_b    [STAGES];
  logic [WIDTH-1:0] w_in_sum  [STAGES];
  logic             w_in_c    [STAGES];
  logic [WIDTH-1:0] w_out_sum [STAGES];
  logic [SEG-1:0]   w_seg_s   [STAGES];
  logic             w_seg_co  [STAGES];
  logic             w_seg_cm  [STAGES];

  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  assign w_adv     = out_ready | ~r_ctl[LAST].valid;
  assign w_b_eff   = b ^ {WIDTH{sub}};
  assign w_cin_eff = sub | cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign w_ctl_in[k] = '{valid: in_valid, sub: sub};
      assign w_in_a[k]   = a;
      assign w_in_b[k]   = w_b_eff;
      assign w_in_sum[k] = '0;
      assign w_in_c[k]   = w_cin_eff;
    end else begin : g_body
      assign w_ctl_in[k] = r_ctl[k-1];
      assign w_in_a[k]   = r_a[k-1];
      assign w_in_b[k]   = r_b[k-1];
      assign w_in_sum[k] = r_sum[k-1];
      assign w_in_c[k]   = r_c[k-1];
    end

    rca_seg #(.W(SEG)) u_seg (
      .a        (w_in_a[k][k*SEG +: SEG]),
      .b        (w_in_b[k][k*SEG +: SEG]),
      .ci       (w_in_c[k]),
      .s        (w_seg_s[k]),
      .co       (w_seg_co[k]),
      .c_msb_in (w_seg_cm[k])
    );

    // Merge this segment's sum slice into the de-skewed partial result.
    assign w_out_sum[k] = (w_in_sum[k] & ~(c_seg_mask << (k*SEG)))
                        | (WIDTH'(w_seg_s[k]) << (k*SEG));
  end

  assign w_ovf = w_seg_co[LAST] ^ w_seg_cm[LAST];

`ifdef ADD_SUB_PIPE_SAT_EN
  localparam logic [WIDTH-1:0] c_sat_max = WIDTH'(sat_max_pat(WIDTH));
  localparam logic [WIDTH-1:0] c_sat_min = WIDTH'(sat_min_pat(WIDTH));

  // A wrapped negative-looking result means the true value overflowed upward.
  assign w_res = !w_ovf ? w_out_sum[LAST]
               : (w_out_sum[LAST][WIDTH-1] ? c_sat_max : c_sat_min);
`else
  assign w_res = w_out_sum[LAST];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_ctl[k] <= '0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= '0;
        r_c[k]   <= 1'b0;
      end
      r_s    <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_adv) begin
      for (int k = 0; k < STAGES; k++) begin
        r_ctl[k] <= w_ctl_in[k];
        r_a[k]   <= w_in_a[k];
        r_b[k]   <= w_in_b[k];
        r_sum[k] <= w_out_sum[k];
        r_c[k]   <= w_seg_co[k];
      end
      // Result registers only move on real beats so bubbles leave them intact.
      if (w_ctl_in[LAST].valid) begin
        r_s    <= w_res;
        r_cout <= w_seg_co[LAST];
        r_ovf  <= w_ovf;
        r_zero <= (w_res == '0);
      end
    end
  end

  assign in_ready  = w_adv;
  assign out_valid = r_ctl[LAST].valid;
  assign s         = r_s;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_add_sub_pipe.sv
// ============================================================================
// Module  : tb_add_sub_pipe
// Self-checking bench for add_sub_pipe (8/2 main instance plus 16-bit sweep).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_add_sub_pipe;

  typedef struct packed {
    logic [15:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a, b, s;
  logic       cin, sub, cout, ovf, zero;

  logic        sw_valid, sw_cin, sw_sub;
  logic [15:0] sw_a, sw_b;
  logic        r1_ir, r1_ov, r1_co, r1_of, r1_z;
  logic        r4_ir, r4_ov, r4_co, r4_of, r4_z;
  logic        r16_ir, r16_ov, r16_co, r16_of, r16_z;
  logic [15:0] r1_s, r4_s, r16_s;

  int n_checks = 0;
  int n_fail   = 0;

  add_sub_pipe #(.WIDTH(8), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf), .zero(zero)
  );

  add_sub_pipe #(.WIDTH(16), .STAGES(1)) u_sw1 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r1_ir),
    .a(sw_a), .b(sw_b), .cin(sw_cin), .sub(sw_sub), .out_valid(r1_ov),
    .out_ready(1'b1), .s(r1_s), .cout(r1_co), .ovf(r1_of), .zero(r1_z)
  );

  add_sub_pipe #(.WIDTH(16), .STAGES(4)) u_sw4 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r4_ir),
    .a(sw_a), .b(sw_b), .cin(sw_cin), .sub(sw_sub), .out_valid(r4_ov),
    .out_ready(1'b1), .s(r4_s), .cout(r4_co), .ovf(r4_of), .zero(r4_z)
  );

  add_sub_pipe #(.WIDTH(16), .STAGES(16)) u_sw16 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r16_ir),
    .a(sw_a), .b(sw_b), .cin(sw_cin), .sub(sw_sub), .out_valid(r16_ov),
    .out_ready(1'b1), .s(r16_s), .cout(r16_co), .ovf(r16_of), .zero(r16_z)
  );

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic res_t model(input int w, input int av, input int bv,
                                 input logic ci, input logic sb);
    res_t r;
    int mask, half, full, sa, sbv, sr;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    if (sb) begin
      full   = av - bv;
      r.cout = (av >= bv);
    end else begin
      full   = av + bv + int'(ci);
      r.cout = (full > mask);
    end
    r.s    = 16'(full & mask);
    sa     = (av >= half) ? av - (1 << w) : av;
    sbv    = (bv >= half) ? bv - (1 << w) : bv;
    sr     = sb ? sa - sbv : sa + sbv + int'(ci);
    r.ovf  = (sr > half - 1) || (sr < -half);
    r.zero = (r.s == 16'd0);
    return r;
  endfunction

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks += 6;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    if (s !== 8'h00)        begin n_fail++; $display("FAIL reset_s: got %h expected 00", s); end
    if (cout !== 1'b0)      begin n_fail++; $display("FAIL reset_cout: got %b expected 0", cout); end
    if (ovf !== 1'b0)       begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    if (zero !== 1'b0)      begin n_fail++; $display("FAIL reset_zero: got %b expected 0", zero); end
    if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    @(negedge clk);
  endtask

  logic [7:0] va  [5] = '{8'h3C, 8'h05, 8'h80, 8'h7F, 8'hFF};
  logic [7:0] vb  [5] = '{8'h15, 8'h07, 8'h01, 8'h01, 8'h01};
  logic       vci [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic       vsb [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [7:0] es  [5] = '{8'h52, 8'hFE, 8'h7F, 8'h80, 8'h00};
  logic       ec  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic       eo  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic       ez  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  task automatic test_vectors();
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = va[i]; b = vb[i]; cin = vci[i]; sub = vsb[i];
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      n_checks += 2;
      if (lat != 2) begin n_fail++; $display("FAIL vec%0d_latency: got %0d expected 2", i, lat); end
      if ({s, cout, ovf, zero} !== {es[i], ec[i], eo[i], ez[i]}) begin
        n_fail++;
        $display("FAIL vec%0d_result: got s=%h c=%b v=%b z=%b expected s=%h c=%b v=%b z=%b",
                 i, s, cout, ovf, zero, es[i], ec[i], eo[i], ez[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int nxt = 1;
    int got = 0;
    logic exp_rdy;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 6);
      in_valid  = (nxt <= 6);
      a = 8'(nxt); b = 8'(nxt); cin = 1'b0; sub = 1'b0;
      #1;
      if (cyc <= 10) begin
        exp_rdy = !(cyc >= 3 && cyc <= 6);
        n_checks++;
        if (in_ready !== exp_rdy) begin
          n_fail++; $display("FAIL bp_in_ready_cyc%0d: got %b expected %b", cyc, in_ready, exp_rdy);
        end
      end
      if (out_valid && out_ready) begin
        got++;
        n_checks++;
        if (s !== 8'(2 * got)) begin
          n_fail++; $display("FAIL bp_beat%0d: got %h expected %h", got, s, 8'(2 * got));
        end
      end
      if (in_valid && in_ready) nxt++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_checks += 2;
    if (got != 6) begin n_fail++; $display("FAIL bp_out_count: got %0d expected 6", got); end
    if (nxt != 7) begin n_fail++; $display("FAIL bp_in_count: got %0d expected 6", nxt - 1); end
  endtask

  task automatic test_random();
    res_t q[$];
    res_t e;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_s = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      if ($urandom_range(0, 7) == 0) begin b = a; sub = 1'b1; end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (prev_stall) begin
        n_checks++;
        if (out_valid !== 1'b1 || s !== prev_s) begin
          n_fail++; $display("FAIL rnd_stall_hold: got v=%b s=%h expected v=1 s=%h", out_valid, s, prev_s);
        end
      end
      if (in_valid && in_ready) q.push_back(model(8, int'(a), int'(b), cin, sub));
      if (out_valid && out_ready) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rnd_spurious: got beat s=%h expected none", s);
        end else begin
          e = q.pop_front();
          if ({s, cout, ovf, zero} !== {e.s[7:0], e.cout, e.ovf, e.zero}) begin
            n_fail++;
            $display("FAIL rnd_result: got s=%h c=%b v=%b z=%b expected s=%h c=%b v=%b z=%b",
                     s, cout, ovf, zero, e.s[7:0], e.cout, e.ovf, e.zero);
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_s     = s;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      #1;
      if (out_valid) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rnd_drain_spurious: got beat s=%h expected none", s);
        end else begin
          e = q.pop_front();
          if ({s, cout, ovf, zero} !== {e.s[7:0], e.cout, e.ovf, e.zero}) begin
            n_fail++; $display("FAIL rnd_drain_result: got s=%h expected s=%h", s, e.s[7:0]);
          end
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (q.size() != 0) begin n_fail++; $display("FAIL rnd_lost_beats: got %0d left expected 0", q.size()); end
  endtask

  task automatic test_reset_midstream();
    int lat;
    out_ready = 1'b0;
    in_valid = 1'b1; a = 8'h01; b = 8'h02; cin = 1'b0; sub = 1'b0;
    @(negedge clk);
    a = 8'h03; b = 8'h04;
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks += 2;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b expected 0", out_valid); end
    if (s !== 8'h00)        begin n_fail++; $display("FAIL rst_mid_s: got %h expected 00", s); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      #1;
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ghost%0d: got %b expected 0", cyc, out_valid); end
      @(negedge clk);
    end
    in_valid = 1'b1; a = 8'h11; b = 8'h22;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    n_checks += 2;
    if (lat != 2)    begin n_fail++; $display("FAIL rst_mid_new_latency: got %0d expected 2", lat); end
    if (s !== 8'h33) begin n_fail++; $display("FAIL rst_mid_new_s: got %h expected 33", s); end
    @(negedge clk);
  endtask

  task automatic test_sweep();
    logic hv [300];
    res_t hr [300];
    logic ev;
    res_t er;
    do_reset();
    for (int cyc = 0; cyc < 300; cyc++) begin
      ev = (cyc >= 1) ? hv[cyc-1] : 1'b0;
      er = (cyc >= 1) ? hr[cyc-1] : '0;
      n_checks++;
      if (r1_ov !== ev || (ev && {r1_s, r1_co, r1_of, r1_z} !== er)) begin
        n_fail++; $display("FAIL sweep_st1_cyc%0d: got v=%b s=%h expected v=%b s=%h", cyc, r1_ov, r1_s, ev, er.s);
      end
      ev = (cyc >= 4) ? hv[cyc-4] : 1'b0;
      er = (cyc >= 4) ? hr[cyc-4] : '0;
      n_checks++;
      if (r4_ov !== ev || (ev && {r4_s, r4_co, r4_of, r4_z} !== er)) begin
        n_fail++; $display("FAIL sweep_st4_cyc%0d: got v=%b s=%h expected v=%b s=%h", cyc, r4_ov, r4_s, ev, er.s);
      end
      ev = (cyc >= 16) ? hv[cyc-16] : 1'b0;
      er = (cyc >= 16) ? hr[cyc-16] : '0;
      n_checks++;
      if (r16_ov !== ev || (ev && {r16_s, r16_co, r16_of, r16_z} !== er)) begin
        n_fail++; $display("FAIL sweep_st16_cyc%0d: got v=%b s=%h expected v=%b s=%h", cyc, r16_ov, r16_s, ev, er.s);
      end
      sw_valid = ($urandom_range(0, 3) != 0);
      sw_a = 16'($urandom); sw_b = 16'($urandom);
      sw_cin = 1'($urandom); sw_sub = 1'($urandom);
      if ($urandom_range(0, 7) == 0) begin sw_b = sw_a; sw_sub = 1'b1; end
      hv[cyc] = sw_valid;
      hr[cyc] = model(16, int'(sw_a), int'(sw_b), sw_cin, sw_sub);
      @(negedge clk);
    end
    sw_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_random();
    test_reset_midstream();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
